// File: rtl/tt_vga_out.sv
`default_nettype none
// ============================================================================
// Module   : tt_vga_out
// Purpose  : VGA timing generator and Tiny VGA PMOD output stage. Publishes
//            the current pixel position to the renderer, delays sync/blank
//            to match the renderer's colour latency, and packs colour and
//            syncs into uo_out in Tiny VGA pin order.
// Options  : define TT_VGA_DITHER_EN to enable 2x2 ordered dithering when
//            COLOR_BITS > 2 (plain truncation otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module tt_vga_out #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 2,   // 2..8
  parameter int LATENCY    = 1    // 0..4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [3*COLOR_BITS-1:0]   pix_rgb,
  output logic [9:0]                hpos,
  output logic [9:0]                vpos,
  output logic                      display_on,
  output logic                      line_start,
  output logic                      frame_start,
  output logic [7:0]                uo_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] C_VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Delay-line word: {hsync, vsync, display_on, hpos[0], vpos[0]}
  localparam logic [4:0] C_DLY_IDLE = {~HSYNC_POL, ~VSYNC_POL, 3'b000};
  localparam logic [7:0] C_UO_IDLE  = {~HSYNC_POL, 3'b000, ~VSYNC_POL, 3'b000};

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic [7:0] r_uo;

  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_de;
  logic       w_hsync;
  logic       w_vsync;
  logic [4:0] w_dly_in;
  logic [4:0] w_dly_out;
  logic [1:0] w_bayer;
  logic [5:0] w_q;       // reduced colour: R at [1:0], G at [3:2], B at [5:4]
  logic [5:0] w_col;
  logic [7:0] w_uo_next;
  logic       w_unused_bayer;

  // Pixel and line counters; both freeze while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (ena) begin
      if (r_hpos == C_H_LAST) begin
        r_hpos <= '0;
        r_vpos <= (r_vpos == C_V_LAST) ? 10'd0 : r_vpos + 10'd1;
      end else begin
        r_hpos <= r_hpos + 10'd1;
      end
    end
  end

  // Undelayed sync windows, blanking and position pulses for the current position.
  always_comb begin
    w_hs_act    = (r_hpos >= C_HS_BEG) && (r_hpos < C_HS_END);
    w_vs_act    = (r_vpos >= C_VS_BEG) && (r_vpos < C_VS_END);
    w_de        = (r_hpos < C_H_VIS) && (r_vpos < C_V_VIS);
    w_hsync     = w_hs_act ? HSYNC_POL : ~HSYNC_POL;
    w_vsync     = w_vs_act ? VSYNC_POL : ~VSYNC_POL;
    line_start  = ena && (r_hpos == 10'd0);
    frame_start = ena && (r_hpos == 10'd0) && (r_vpos == 10'd0);
  end

  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign display_on = w_de;
  assign w_dly_in   = {w_hsync, w_vsync, w_de, r_hpos[0], r_vpos[0]};

  // Align sync/blank with the renderer's colour latency.
  generate
    if (LATENCY == 0) begin : g_no_delay
      assign w_dly_out = w_dly_in;
    end else begin : g_delay
      logic [4:0] r_stage [LATENCY];

      // Shift register stepping only while enabled; clears to blank/inactive syncs.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) r_stage[i] <= C_DLY_IDLE;
        end else if (ena) begin
          r_stage[0] <= w_dly_in;
          for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign w_dly_out = r_stage[LATENCY-1];
    end
  endgenerate

  // Ordered-dither threshold from the delayed {vpos[0], hpos[0]}: [0,2;3,1].
  always_comb begin
    case ({w_dly_out[0], w_dly_out[1]})
      2'b00:   w_bayer = 2'd0;
      2'b01:   w_bayer = 2'd2;
      2'b10:   w_bayer = 2'd3;
      default: w_bayer = 2'd1;
    endcase
  end

  // The threshold is only consumed by the dithered build.
  assign w_unused_bayer = ^w_bayer;

  // Reduce each channel to 2 bits.
  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      logic [COLOR_BITS-1:0] w_c;
      assign w_c = pix_rgb[(3-ch)*COLOR_BITS-1 -: COLOR_BITS];
`ifdef TT_VGA_DITHER_EN
      if (COLOR_BITS > 2) begin : g_dither
        localparam int D = COLOR_BITS - 2;
        logic [COLOR_BITS+1:0] w_bias;
        logic [COLOR_BITS+1:0] w_sum;
        logic [COLOR_BITS+1:0] w_shr;
        assign w_bias = ({{COLOR_BITS{1'b0}}, w_bayer} << D) >> 2;
        assign w_sum  = {2'b00, w_c} + w_bias;
        assign w_shr  = w_sum >> D;
        // Saturate: rounding up from the top code must not wrap.
        assign w_q[2*ch +: 2] = (w_shr > {{COLOR_BITS{1'b0}}, 2'b11}) ? 2'd3 : w_shr[1:0];
      end else begin : g_trunc
        assign w_q[2*ch +: 2] = w_c[COLOR_BITS-1 -: 2];
      end
`else
      assign w_q[2*ch +: 2] = w_c[COLOR_BITS-1 -: 2];
      if (COLOR_BITS > 2) begin : g_lsb
        logic w_unused_lsb;
        assign w_unused_lsb = ^w_c[COLOR_BITS-3:0];
      end
`endif
    end
  endgenerate

  // Blank colour outside the visible area and pack in Tiny VGA pin order.
  always_comb begin
    w_col     = w_dly_out[2] ? w_q : 6'd0;
    w_uo_next = {w_dly_out[4], w_col[4], w_col[2], w_col[0],
                 w_dly_out[3], w_col[5], w_col[3], w_col[1]};
  end

  // Output register: holds while disabled, idles on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_uo <= C_UO_IDLE;
    end else if (ena) begin
      r_uo <= w_uo_next;
    end
  end

  assign uo_out = r_uo;

endmodule
`default_nettype wire

// File: tb/tb_tt_vga_out.sv
`default_nettype none
module tb_tt_vga_out;

`ifdef TT_VGA_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        ena   = 1'b1;
  logic [5:0]  pix0  = '0;
  logic [11:0] pix1  = '0;

  logic [9:0] hpos0, vpos0, hpos1, vpos1;
  logic       de0, de1, ls0, ls1, fs0, fs1;
  logic [7:0] uo0, uo1;

  // Default timing, COLOR_BITS=2, LATENCY=1, active-low syncs
  tt_vga_out u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pix_rgb(pix0),
    .hpos(hpos0), .vpos(vpos0), .display_on(de0),
    .line_start(ls0), .frame_start(fs0), .uo_out(uo0)
  );

  // Tiny frame (15x11), COLOR_BITS=4, LATENCY=2, active-high syncs
  tt_vga_out #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_BITS(4), .LATENCY(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pix_rgb(pix1),
    .hpos(hpos1), .vpos(vpos1), .display_on(de1),
    .line_start(ls1), .frame_start(fs1), .uo_out(uo1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int h0; int v0; logic [7:0] uo0;
    int h1; int v1; logic [7:0] uo1;
  } exp_t;

  exp_t eq[$];
  exp_t mon_e;
  int   pq0[$];
  int   pq1[$];
  int   m_h [2];
  int   m_v [2];
  logic [7:0] m_uo [2];

  // Reference pixel for a position (pos<0 means the reset/blank state).
  function automatic logic [7:0] exp_uo(input int sel, input int pos, input logic [23:0] pix);
    int hv, hf, hs, vv, vf, vs, cb;
    bit hp, vp;
    int h, v, val, q, b, d;
    int bay [4];
    logic [7:0] r;
    bay = '{0, 2, 3, 1};
    if (sel == 0) begin
      hv = 640; hf = 16; hs = 96; vv = 480; vf = 10; vs = 2; cb = 2; hp = 1'b0; vp = 1'b0;
    end else begin
      hv = 8; hf = 2; hs = 3; vv = 6; vf = 1; vs = 2; cb = 4; hp = 1'b1; vp = 1'b1;
    end
    r = 8'h00;
    if (pos < 0) begin
      r[7] = ~hp; r[3] = ~vp;
      return r;
    end
    h = pos % 1024;
    v = pos / 1024;
    r[7] = (h >= hv + hf && h < hv + hf + hs) ? hp : ~hp;
    r[3] = (v >= vv + vf && v < vv + vf + vs) ? vp : ~vp;
    if (h < hv && v < vv) begin
      for (int c = 0; c < 3; c++) begin
        val = int'((pix >> ((2 - c) * cb)) & ((24'd1 << cb) - 24'd1));
        if (DITH && cb > 2) begin
          d = cb - 2;
          b = bay[(v % 2) * 2 + (h % 2)];
          q = (val + ((b << d) >> 2)) >> d;
          if (q > 3) q = 3;
        end else begin
          q = val >> (cb - 2);
        end
        r[c]     = q[1];
        r[c + 4] = q[0];
      end
    end
    return r;
  endfunction

  // Drive one clock of stimulus and push what both DUTs must show after it.
  task automatic step(input bit en, input logic [5:0] p0, input logic [11:0] p1);
    exp_t e;
    int   pd;
    ena  = en;
    pix0 = p0;
    pix1 = p1;
    if (!rst_n) begin
      m_h[0] = 0; m_v[0] = 0; m_h[1] = 0; m_v[1] = 0;
      pq0.delete(); pq0.push_back(-1);
      pq1.delete(); pq1.push_back(-1); pq1.push_back(-1);
      m_uo[0] = 8'h88;
      m_uo[1] = 8'h00;
    end else if (en) begin
      pq0.push_back(m_h[0] + 1024 * m_v[0]);
      pd = pq0.pop_front();
      m_uo[0] = exp_uo(0, pd, {18'd0, p0});
      pq1.push_back(m_h[1] + 1024 * m_v[1]);
      pd = pq1.pop_front();
      m_uo[1] = exp_uo(1, pd, {12'd0, p1});
      for (int k = 0; k < 2; k++) begin
        m_h[k]++;
        if (m_h[k] == ((k == 0) ? 800 : 15)) begin
          m_h[k] = 0;
          m_v[k]++;
          if (m_v[k] == ((k == 0) ? 525 : 11)) m_v[k] = 0;
        end
      end
    end
    e.h0 = m_h[0]; e.v0 = m_v[0]; e.uo0 = m_uo[0];
    e.h1 = m_h[1]; e.v1 = m_v[1]; e.uo1 = m_uo[1];
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every expected state on the falling edge.
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      mon_e = eq.pop_front();
      n_cmp++; if (uo0 !== mon_e.uo0) begin n_bad++; $display("FAIL sb_uo0 t=%0t got %02h want %02h", $time, uo0, mon_e.uo0); end
      n_cmp++; if (hpos0 !== 10'(mon_e.h0)) begin n_bad++; $display("FAIL sb_hpos0 t=%0t got %0d want %0d", $time, hpos0, mon_e.h0); end
      n_cmp++; if (vpos0 !== 10'(mon_e.v0)) begin n_bad++; $display("FAIL sb_vpos0 t=%0t got %0d want %0d", $time, vpos0, mon_e.v0); end
      n_cmp++; if (de0 !== (mon_e.h0 < 640 && mon_e.v0 < 480)) begin n_bad++; $display("FAIL sb_de0 t=%0t got %b", $time, de0); end
      n_cmp++; if (ls0 !== (ena && mon_e.h0 == 0)) begin n_bad++; $display("FAIL sb_ls0 t=%0t got %b", $time, ls0); end
      n_cmp++; if (fs0 !== (ena && mon_e.h0 == 0 && mon_e.v0 == 0)) begin n_bad++; $display("FAIL sb_fs0 t=%0t got %b", $time, fs0); end
      n_cmp++; if (uo1 !== mon_e.uo1) begin n_bad++; $display("FAIL sb_uo1 t=%0t got %02h want %02h", $time, uo1, mon_e.uo1); end
      n_cmp++; if (hpos1 !== 10'(mon_e.h1)) begin n_bad++; $display("FAIL sb_hpos1 t=%0t got %0d want %0d", $time, hpos1, mon_e.h1); end
      n_cmp++; if (vpos1 !== 10'(mon_e.v1)) begin n_bad++; $display("FAIL sb_vpos1 t=%0t got %0d want %0d", $time, vpos1, mon_e.v1); end
      n_cmp++; if (de1 !== (mon_e.h1 < 8 && mon_e.v1 < 6)) begin n_bad++; $display("FAIL sb_de1 t=%0t got %b", $time, de1); end
      n_cmp++; if (ls1 !== (ena && mon_e.h1 == 0)) begin n_bad++; $display("FAIL sb_ls1 t=%0t got %b", $time, ls1); end
      n_cmp++; if (fs1 !== (ena && mon_e.h1 == 0 && mon_e.v1 == 0)) begin n_bad++; $display("FAIL sb_fs1 t=%0t got %b", $time, fs1); end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 6'h3f, 12'hfff);
      n_cmp++; if (uo0 !== 8'h88) begin n_bad++; $display("FAIL reset_idle0 got %02h want 88", uo0); end
      n_cmp++; if (uo1 !== 8'h00) begin n_bad++; $display("FAIL reset_idle1 got %02h want 00", uo1); end
    end
    rst_n = 1'b1;
    n_cmp++; if (hpos0 !== 10'd0 || vpos0 !== 10'd0) begin n_bad++; $display("FAIL release_pos got %0d,%0d want 0,0", hpos0, vpos0); end
    n_cmp++; if (fs0 !== 1'b1) begin n_bad++; $display("FAIL release_fs0 got %b want 1", fs0); end
    n_cmp++; if (fs1 !== 1'b1) begin n_bad++; $display("FAIL release_fs1 got %b want 1", fs1); end
  endtask

  task automatic test_colour();
    for (int i = 0; i < 900; i++) begin
      step(1'b1, 6'b11_01_10, 12'($urandom));
      if (m_h[0] == 10 && m_v[0] == 0) begin
        n_cmp++; if ((uo0 & 8'h77) !== 8'h35) begin n_bad++; $display("FAIL colour_visible got %02h want 35", uo0 & 8'h77); end
      end
      if (m_h[0] == 702 && m_v[0] == 0) begin
        n_cmp++; if ((uo0 & 8'h77) !== 8'h00) begin n_bad++; $display("FAIL colour_blank got %02h want 00", uo0 & 8'h77); end
      end
    end
  endtask

  task automatic test_hsync();
    int start = -1, run = 0, len = -1, ls_a = -1, ls_b = -1;
    logic prev, cur;
    prev = uo0[7];
    for (int i = 0; i < 1700; i++) begin
      step(1'b1, 6'($urandom), 12'($urandom));
      cur = uo0[7];
      if (start >= 0 && len < 0) begin
        if (!cur) run++;
        else len = run;
      end
      if (prev && !cur && start < 0) begin
        start = m_h[0];
        run   = 1;
      end
      if (ls0) begin
        if (ls_a < 0) ls_a = i;
        else if (ls_b < 0) ls_b = i;
      end
      prev = cur;
    end
    n_cmp++; if (start !== 658) begin n_bad++; $display("FAIL hsync_start got hpos %0d want 658", start); end
    n_cmp++; if (len !== 96) begin n_bad++; $display("FAIL hsync_width got %0d want 96", len); end
    n_cmp++; if (ls_b - ls_a !== 800 || ls_a < 0) begin n_bad++; $display("FAIL line_period got %0d want 800", ls_b - ls_a); end
  endtask

  task automatic test_ena_freeze();
    logic [9:0] h_hold;
    logic [7:0] u_hold;
    for (int i = 0; i < 800 && m_h[0] != 300; i++) step(1'b1, 6'($urandom), 12'($urandom));
    h_hold = hpos0;
    u_hold = uo0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 6'($urandom), 12'($urandom));
      n_cmp++; if (hpos0 !== h_hold) begin n_bad++; $display("FAIL freeze_hpos got %0d want %0d", hpos0, h_hold); end
      n_cmp++; if (uo0 !== u_hold) begin n_bad++; $display("FAIL freeze_uo got %02h want %02h", uo0, u_hold); end
    end
    step(1'b1, 6'($urandom), 12'($urandom));
    n_cmp++; if (hpos0 !== h_hold + 10'd1) begin n_bad++; $display("FAIL resume_hpos got %0d want %0d", hpos0, h_hold + 10'd1); end
  endtask

  task automatic test_frame();
    int fa = -1, fb = -1, vs_cnt = 0;
    for (int i = 0; i < 400 && fb < 0; i++) begin
      step(1'b1, 6'($urandom), 12'($urandom));
      if (fa >= 0 && !fs1) vs_cnt += int'(uo1[3]);
      if (fs1) begin
        if (fa < 0) fa = i;
        else fb = i;
      end
    end
    n_cmp++; if (fb - fa !== 165 || fa < 0) begin n_bad++; $display("FAIL frame_period got %0d want 165", fb - fa); end
    n_cmp++; if (vs_cnt !== 30) begin n_bad++; $display("FAIL vsync_cycles got %0d want 30", vs_cnt); end
  endtask

  task automatic test_dither();
    logic [7:0] w_up;
    int seen = 0;
    w_up = DITH ? 8'h07 : 8'h70;
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 6'($urandom), 12'h666);
      if (i > 10 && m_v[1] == 0 && m_h[1] == 3) begin
        seen++; n_cmp++; if (uo1 !== 8'h70) begin n_bad++; $display("FAIL dither_00 got %02h want 70", uo1); end
      end
      if (i > 10 && m_v[1] == 0 && m_h[1] == 4) begin
        seen++; n_cmp++; if (uo1 !== w_up) begin n_bad++; $display("FAIL dither_01 got %02h want %02h", uo1, w_up); end
      end
      if (i > 10 && m_v[1] == 1 && m_h[1] == 3) begin
        seen++; n_cmp++; if (uo1 !== w_up) begin n_bad++; $display("FAIL dither_10 got %02h want %02h", uo1, w_up); end
      end
      if (i > 10 && m_v[1] == 1 && m_h[1] == 4) begin
        seen++; n_cmp++; if (uo1 !== 8'h70) begin n_bad++; $display("FAIL dither_11 got %02h want 70", uo1); end
      end
    end
    n_cmp++; if (seen < 4) begin n_bad++; $display("FAIL dither_coverage got %0d want >=4", seen); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 137; i++) step(1'b1, 6'($urandom), 12'($urandom));
    rst_n = 1'b0;
    step(1'b1, 6'($urandom), 12'($urandom));
    step(1'b0, 6'($urandom), 12'($urandom));
    rst_n = 1'b1;
    n_cmp++; if (hpos0 !== 10'd0 || vpos0 !== 10'd0) begin n_bad++; $display("FAIL midreset_pos got %0d,%0d want 0,0", hpos0, vpos0); end
    n_cmp++; if (uo0 !== 8'h88) begin n_bad++; $display("FAIL midreset_uo0 got %02h want 88", uo0); end
    n_cmp++; if (uo1 !== 8'h00) begin n_bad++; $display("FAIL midreset_uo1 got %02h want 00", uo1); end
    for (int i = 0; i < 40; i++) step(1'b1, 6'($urandom), 12'($urandom));
  endtask

  initial begin
    test_reset();
    test_colour();
    test_hsync();
    test_ena_freeze();
    test_frame();
    test_dither();
    test_reset_midframe();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
